// File: rtl/stage4_memory_pkg.sv
// rtl/stage4_memory_pkg.sv - shared types for the memory pipeline stage
package stage4_memory_pkg;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_IMM   = 7'b0010011,
        OP_STORE = 7'b0100011
    } opcode_t;

    // Load and store funct3 encodings share values for the byte/half/word sizes.
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] immediate;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        logic [31:0]          rs1_value;
        logic [31:0]          rs2_value;
        logic [31:0]          alu_result;
        logic                 branch_taken;
        logic [31:0]          branch_target;
    } execute_to_memory_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        logic [31:0]          alu_result;
        logic [31:0]          load_data;
        logic                 misaligned;
    } memory_to_writeback_t;

    localparam int EXEC_WIDTH = $bits(execute_to_memory_t);
    localparam int WB_WIDTH   = $bits(memory_to_writeback_t);

endpackage

// File: rtl/stage4_memory_load_store_align.sv
// rtl/stage4_memory_load_store_align.sv - store lane strobes/data and load extraction/extension
module stage4_memory_load_store_align
    import stage4_memory_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rdata >> {lane, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    // Decode size from funct3; LB/SB, LH/SH and LW/SW share encodings so one case covers both.
    always_comb begin
        wstrb      = 4'b0000;
        wdata      = rs2;
        misaligned = 1'b0;
        load_data  = rdata;
        case (funct3)
            LB: begin
                wstrb     = 4'b0001 << lane;
                wdata     = {4{rs2[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            LH: begin
                misaligned = lane[0];
                wstrb      = 4'b0011 << lane;
                wdata      = {2{rs2[15:0]}};
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            LW: begin
                misaligned = (lane != 2'b00);
                wstrb      = 4'b1111;
                wdata      = rs2;
                load_data  = rdata;
            end
            LBU: begin
                misaligned = is_store;
                load_data  = {24'd0, byte_sel};
            end
            LHU: begin
                misaligned = is_store | lane[0];
                load_data  = {16'd0, half_sel};
            end
            default: begin
                misaligned = 1'b1;
                load_data  = 32'd0;
            end
        endcase
        if (!is_store) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/stage4_memory.sv
// rtl/stage4_memory.sv - pipeline stage 4: data-memory access and in-order forwarding to writeback
module stage4_memory
    import stage4_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXEC_WIDTH-1:0] axis_execute_to_memory_tdata,
    input  logic                  axis_execute_to_memory_tvalid,
    output logic                  axis_execute_to_memory_tready,
    output logic [WB_WIDTH-1:0]   axis_memory_to_writeback_tdata,
    output logic                  axis_memory_to_writeback_tvalid,
    input  logic                  axis_memory_to_writeback_tready,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [ADDR_WIDTH-1:0] dmem_req_addr,
    output logic                  dmem_req_we,
    output logic [3:0]            dmem_req_wstrb,
    output logic [DATA_WIDTH-1:0] dmem_req_wdata,
    input  logic                  dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
    output logic                  mem_busy
);

    execute_to_memory_t   in_pkt;
    memory_to_writeback_t out_pkt;
    mem_state_t           state;

    decoded_instruction_t cap_instr;
    logic [31:0]          cap_alu;
    logic [1:0]           cap_lane;

    logic [31:0] in_ea;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_mem;
    logic        take;
    logic        out_accept;

    logic        sel_store;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_lane;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic        align_misaligned;
    logic [31:0] align_load_data;

    // Branch fields pass through this stage untouched and are consumed elsewhere.
    logic unused_branch;
    assign unused_branch = ^{in_pkt.branch_taken, in_pkt.branch_target};

    assign in_pkt      = execute_to_memory_t'(axis_execute_to_memory_tdata);
    assign in_ea       = in_pkt.rs1_value + in_pkt.decoded_instruction.immediate;
    assign in_is_load  = (in_pkt.decoded_instruction.opcode == OP_LOAD);
    assign in_is_store = (in_pkt.decoded_instruction.opcode == OP_STORE);
    assign in_is_mem   = in_is_load | in_is_store;

    assign out_accept = axis_memory_to_writeback_tvalid & axis_memory_to_writeback_tready;
    assign axis_execute_to_memory_tready = !rst && (state == IDLE) &&
                                           (!axis_memory_to_writeback_tvalid || axis_memory_to_writeback_tready);
    assign take = axis_execute_to_memory_tvalid & axis_execute_to_memory_tready;

    assign axis_memory_to_writeback_tdata = out_pkt;
    assign mem_busy = (state != IDLE);

    // In IDLE the aligner sees the incoming op; afterwards it sees the captured load for formatting.
    assign sel_store  = (state == IDLE) ? in_is_store : 1'b0;
    assign sel_funct3 = (state == IDLE) ? in_pkt.decoded_instruction.funct3 : cap_instr.funct3;
    assign sel_lane   = (state == IDLE) ? in_ea[1:0] : cap_lane;

    stage4_memory_load_store_align u_align (
        .is_store   (sel_store),
        .funct3     (sel_funct3),
        .lane       (sel_lane),
        .rs2        (in_pkt.rs2_value),
        .rdata      (dmem_resp_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .misaligned (align_misaligned),
        .load_data  (align_load_data)
    );

    // Stage FSM: owns the output register, the memory request and the captured access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                           <= IDLE;
            axis_memory_to_writeback_tvalid <= 1'b0;
            out_pkt                         <= '0;
            dmem_req_valid                  <= 1'b0;
            dmem_req_addr                   <= '0;
            dmem_req_we                     <= 1'b0;
            dmem_req_wstrb                  <= 4'b0000;
            dmem_req_wdata                  <= '0;
            cap_instr                       <= '0;
            cap_alu                         <= '0;
            cap_lane                        <= 2'b00;
        end else begin
            if (out_accept) begin
                axis_memory_to_writeback_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        if (in_is_mem && !align_misaligned) begin
                            cap_instr      <= in_pkt.decoded_instruction;
                            cap_alu        <= in_pkt.alu_result;
                            cap_lane       <= in_ea[1:0];
                            dmem_req_valid <= 1'b1;
                            dmem_req_addr  <= {in_ea[ADDR_WIDTH-1:2], 2'b00};
                            dmem_req_we    <= in_is_store;
                            dmem_req_wstrb <= align_wstrb;
                            dmem_req_wdata <= align_wdata;
                            state          <= REQ;
                        end else begin
                            // Non-memory ops and rejected accesses go straight to writeback.
                            axis_memory_to_writeback_tvalid <= 1'b1;
                            out_pkt.decoded_instruction     <= in_pkt.decoded_instruction;
                            out_pkt.alu_result              <= in_pkt.alu_result;
                            out_pkt.load_data               <= 32'd0;
                            out_pkt.misaligned              <= in_is_mem;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        dmem_req_wstrb <= 4'b0000;
                        if (dmem_req_we) begin
                            axis_memory_to_writeback_tvalid <= 1'b1;
                            out_pkt.decoded_instruction     <= cap_instr;
                            out_pkt.alu_result              <= cap_alu;
                            out_pkt.load_data               <= 32'd0;
                            out_pkt.misaligned              <= 1'b0;
                            state                           <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_resp_valid) begin
                        axis_memory_to_writeback_tvalid <= 1'b1;
                        out_pkt.decoded_instruction     <= cap_instr;
                        out_pkt.alu_result              <= cap_alu;
                        out_pkt.load_data               <= align_load_data;
                        out_pkt.misaligned              <= 1'b0;
                        state                           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
